// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: ResultSrc selects, load/store
// funct3 codes and the bus-access FSM state type.
package riscv_pkg;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus request/response bundle between the memory stage (master)
// and the data memory / bus fabric (slave).
interface mem_stage_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/lsu_align.sv
// Load/store lane alignment: store data replication and byte strobes,
// load lane extraction with sign/zero extension, and detection of
// misaligned or reserved-size accesses.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        is_store,
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = load_raw[{addr_lo, 3'b000} +: 8];
    assign half_sel = load_raw[{addr_lo[1], 4'b0000} +: 16];

    // Lane steering and fault decode for the current M-stage access.
    always_comb begin
        wdata      = store_data;
        wstrb      = '0;
        load_data  = load_raw;
        misaligned = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wdata = {4{store_data[7:0]}};
                    wstrb = 4'b0001 << addr_lo;
                end
                F3_SH: begin
                    wdata = {2{store_data[15:0]}};
                    if (addr_lo[0]) misaligned = 1'b1;
                    else            wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                F3_SW: begin
                    if (addr_lo != 2'b00) misaligned = 1'b1;
                    else                  wstrb = 4'b1111;
                end
                default: misaligned = 1'b1;
            endcase
        end else if (is_load) begin
            case (funct3)
                F3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
                F3_LBU: load_data = {24'h000000, byte_sel};
                F3_LH: begin
                    load_data  = {{16{half_sel[15]}}, half_sel};
                    misaligned = addr_lo[0];
                end
                F3_LHU: begin
                    load_data  = {16'h0000, half_sel};
                    misaligned = addr_lo[0];
                end
                F3_LW:  misaligned = (addr_lo != 2'b00);
                default: misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-bus accesses, stalls the front of the
// pipe while waiting for mem_ack, and owns the MEM/WB register.
// Optional feature: define MEM_TIMEOUT_EN to abandon a bus access after
// TIMEOUT_CYCLES without acknowledge (reported as a one-cycle FaultM).
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWriteM,
    input  logic               MemWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic [2:0]         funct3M,
    input  logic [4:0]         rdM,
    input  logic [31:0]        PCplus4M,
    input  logic [31:0]        ALUResultM,
    input  logic [31:0]        WriteDataM,
    mem_stage_if.master        bus,
    output logic               StallM,
    output logic               FaultM,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [4:0]         rdW,
    output logic [31:0]        ALUResultW,
    output logic [31:0]        ReadDataW,
    output logic [31:0]        PCplus4W
);

    mem_state_t  state, state_next;
    logic        is_store, is_load;
    logic        misaligned;
    logic        timeout;
    logic        pending;
    logic [31:0] load_data;

    assign is_store = MemWriteM;
    assign is_load  = ~MemWriteM & (ResultSrcM == RESULT_LOAD);

    lsu_align u_lsu_align (
        .is_store   (is_store),
        .is_load    (is_load),
        .funct3     (funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .load_raw   (bus.mem_rdata),
        .wdata      (bus.mem_wdata),
        .wstrb      (bus.mem_wstrb),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // A timed-out access counts as faulting, so it drops out of pending too.
    assign pending = (is_store | is_load) & ~misaligned & ~timeout & ~reset;
    assign FaultM  = misaligned | timeout;
    assign StallM  = pending & ~bus.mem_ack;

    assign bus.mem_req  = pending;
    assign bus.mem_we   = MemWriteM;
    assign bus.mem_addr = {ALUResultM[31:2], 2'b00};

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts cycles spent in WAIT; the IDLE cycle that issued the request
    // plus TIMEOUT_CYCLES-1 WAIT cycles make up the stall window.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT || state_next != WAIT) wait_cnt <= '0;
        else                                             wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = ~reset & (state == WAIT) & ~bus.mem_ack & (wait_cnt == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Bus-access FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: park in WAIT until the outstanding access is acknowledged.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pending && !bus.mem_ack) state_next = WAIT;
            WAIT: if (!pending || bus.mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MEM/WB register: bubble while stalled, kill writeback on a fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            rdW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCplus4W   <= '0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~FaultM;
            ResultSrcW <= ResultSrcM;
            rdW        <= rdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (is_load & ~FaultM) ? load_data : '0;
            PCplus4W   <= PCplus4M;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed vectors.
// Build with MEM_TIMEOUT_EN defined to exercise the bus timeout path.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  rdM;
    logic [31:0] PCplus4M, ALUResultM, WriteDataM;
    logic        StallM, FaultM, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  rdW;
    logic [31:0] ALUResultW, ReadDataW, PCplus4W;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .rdM        (rdM),
        .PCplus4M   (PCplus4M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .bus        (bus.master),
        .StallM     (StallM),
        .FaultM     (FaultM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .rdW        (rdW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCplus4W   (PCplus4W)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_m();
        RegWriteM     = 1'b0;
        MemWriteM     = 1'b0;
        ResultSrcM    = RESULT_ALU;
        funct3M       = 3'b000;
        rdM           = '0;
        PCplus4M      = '0;
        ALUResultM    = '0;
        WriteDataM    = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data, input logic ack);
        idle_m();
        MemWriteM   = 1'b1;
        funct3M     = f3;
        ALUResultM  = addr;
        WriteDataM  = data;
        bus.mem_ack = ack;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic ack);
        idle_m();
        RegWriteM     = 1'b1;
        ResultSrcM    = RESULT_LOAD;
        funct3M       = f3;
        ALUResultM    = addr;
        rdM           = rd;
        bus.mem_rdata = rdata;
        bus.mem_ack   = ack;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_m();
        tick();
        tick();
        // Reset state, with a load presented during reset.
        load(F3_LW, 32'h0000_0100, 5'd3, 32'h0, 1'b0);
        settle();
        check("rst_req",   32'(bus.mem_req), 32'd0);
        check("rst_stall", 32'(StallM),      32'd0);
        check("rst_rw",    32'(RegWriteW),   32'd0);
        check("rst_alu",   ALUResultW,       32'd0);
        check("rst_rd",    32'(rdW),         32'd0);
        check("rst_rdat",  ReadDataW,        32'd0);
        idle_m();
        tick();
        reset = 1'b0;

        // SW zero-wait.
        store(F3_SW, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
        settle();
        check("sw_req",   32'(bus.mem_req), 32'd1);
        check("sw_we",    32'(bus.mem_we),  32'd1);
        check("sw_addr",  bus.mem_addr,     32'h0000_0100);
        check("sw_wdata", bus.mem_wdata,    32'hDEAD_BEEF);
        check("sw_wstrb", 32'(bus.mem_wstrb), 32'hF);
        check("sw_stall", 32'(StallM),      32'd0);
        check("sw_fault", 32'(FaultM),      32'd0);
        tick();
        check("sw_rw",    32'(RegWriteW),   32'd0);
        check("sw_aluw",  ALUResultW,       32'h0000_0100);

        // SB to lane 3 and SH to upper half.
        store(F3_SB, 32'h0000_0103, 32'h0000_00AB, 1'b1);
        settle();
        check("sb_addr",  bus.mem_addr,       32'h0000_0100);
        check("sb_wdata", bus.mem_wdata,      32'hABAB_ABAB);
        check("sb_wstrb", 32'(bus.mem_wstrb), 32'h8);
        tick();
        store(F3_SB, 32'h0000_0101, 32'h0000_0077, 1'b1);
        settle();
        check("sb1_wstrb", 32'(bus.mem_wstrb), 32'h2);
        tick();
        store(F3_SH, 32'h0000_0102, 32'h0000_1234, 1'b1);
        settle();
        check("sh_wdata", bus.mem_wdata,      32'h1234_1234);
        check("sh_wstrb", 32'(bus.mem_wstrb), 32'hC);
        tick();

        // LB with three wait cycles.
        load(F3_LB, 32'h0000_0201, 5'd5, 32'h0000_8000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("lb_stall%0d", i), 32'(StallM), 32'd1);
            check($sformatf("lb_req%0d", i),   32'(bus.mem_req), 32'd1);
            tick();
            check($sformatf("lb_bub%0d", i),   32'(RegWriteW), 32'd0);
        end
        bus.mem_ack = 1'b1;
        settle();
        check("lb_ackst", 32'(StallM),        32'd0);
        check("lb_wstrb", 32'(bus.mem_wstrb), 32'h0);
        check("lb_addr",  bus.mem_addr,       32'h0000_0200);
        tick();
        check("lb_rw",    32'(RegWriteW), 32'd1);
        check("lb_rd",    32'(rdW),       32'd5);
        check("lb_data",  ReadDataW,      32'hFFFF_FF80);
        check("lb_src",   32'(ResultSrcW), 32'(RESULT_LOAD));

        // Zero-wait loads of each size.
        load(F3_LBU, 32'h0000_0201, 5'd6, 32'h0000_8000, 1'b1);
        settle();
        check("lbu_stall", 32'(StallM), 32'd0);
        tick();
        check("lbu_data", ReadDataW, 32'h0000_0080);
        load(F3_LH, 32'h0000_0202, 5'd7, 32'h8001_0000, 1'b1);
        tick();
        check("lh_data", ReadDataW, 32'hFFFF_8001);
        load(F3_LHU, 32'h0000_0202, 5'd7, 32'h8001_0000, 1'b1);
        tick();
        check("lhu_data", ReadDataW, 32'h0000_8001);
        load(F3_LW, 32'h0000_0204, 5'd8, 32'h1234_5678, 1'b1);
        tick();
        check("lw_data", ReadDataW, 32'h1234_5678);

        // Faulting accesses.
        load(F3_LW, 32'h0000_0202, 5'd9, 32'h0, 1'b0);
        settle();
        check("lwmis_fault", 32'(FaultM),      32'd1);
        check("lwmis_req",   32'(bus.mem_req), 32'd0);
        check("lwmis_stall", 32'(StallM),      32'd0);
        tick();
        check("lwmis_rw",    32'(RegWriteW),   32'd0);
        load(F3_LHU, 32'h0000_0203, 5'd9, 32'h0, 1'b0);
        settle();
        check("lhmis_fault", 32'(FaultM), 32'd1);
        tick();
        load(3'b110, 32'h0000_0200, 5'd9, 32'h0, 1'b0);
        settle();
        check("ldres_fault", 32'(FaultM), 32'd1);
        tick();
        store(3'b011, 32'h0000_0200, 32'h0, 1'b0);
        settle();
        check("stres_fault", 32'(FaultM),      32'd1);
        check("stres_req",   32'(bus.mem_req), 32'd0);
        tick();
        store(F3_SH, 32'h0000_0201, 32'h0, 1'b0);
        settle();
        check("shmis_fault", 32'(FaultM), 32'd1);
        tick();

        // Non-memory ops; ack without a request is ignored.
        idle_m();
        RegWriteM   = 1'b1;
        rdM         = 5'd7;
        ALUResultM  = 32'h0000_0055;
        bus.mem_ack = 1'b1;
        settle();
        check("alu_req",   32'(bus.mem_req), 32'd0);
        check("alu_stall", 32'(StallM),      32'd0);
        check("alu_fault", 32'(FaultM),      32'd0);
        tick();
        check("alu_rw",  32'(RegWriteW), 32'd1);
        check("alu_res", ALUResultW,     32'h0000_0055);
        check("alu_rd",  32'(rdW),       32'd7);
        idle_m();
        RegWriteM  = 1'b1;
        ResultSrcM = RESULT_PC4;
        PCplus4M   = 32'h0000_1004;
        tick();
        check("pc4_val", PCplus4W,        32'h0000_1004);
        check("pc4_src", 32'(ResultSrcW), 32'(RESULT_PC4));

        // Reset while in WAIT, ack arriving during and after reset.
        load(F3_LW, 32'h0000_0300, 5'd10, 32'hCAFE_F00D, 1'b0);
        tick();
        settle();
        check("rw_stall", 32'(StallM), 32'd1);
        reset       = 1'b1;
        bus.mem_ack = 1'b1;
        settle();
        check("rw_req",   32'(bus.mem_req), 32'd0);
        check("rw_stl2",  32'(StallM),      32'd0);
        tick();
        check("rw_rw",    32'(RegWriteW), 32'd0);
        check("rw_rdat",  ReadDataW,      32'd0);
        check("rw_alu",   ALUResultW,     32'd0);
        check("rw_pc4",   PCplus4W,       32'd0);
        check("rw_rd",    32'(rdW),       32'd0);
        reset = 1'b0;
        idle_m();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        settle();
        check("late_req", 32'(bus.mem_req), 32'd0);
        tick();
        check("late_rw",   32'(RegWriteW), 32'd0);
        check("late_rdat", ReadDataW,      32'd0);

`ifdef MEM_TIMEOUT_EN
        // Timeout after four stalled cycles.
        load(F3_LW, 32'h0000_0400, 5'd11, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("to_stall%0d", i), 32'(StallM), 32'd1);
            check($sformatf("to_flt%0d", i),   32'(FaultM), 32'd0);
            tick();
        end
        settle();
        check("to_fault", 32'(FaultM),      32'd1);
        check("to_stall", 32'(StallM),      32'd0);
        check("to_req",   32'(bus.mem_req), 32'd0);
        tick();
        check("to_rw",    32'(RegWriteW), 32'd0);
        settle();
        check("to_pulse", 32'(FaultM), 32'd0);
        idle_m();
        tick();
`else
        // Without the timeout the stall is held indefinitely.
        load(F3_LW, 32'h0000_0400, 5'd11, 32'h0BAD_F00D, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        settle();
        check("hold_stall", 32'(StallM),      32'd1);
        check("hold_fault", 32'(FaultM),      32'd0);
        check("hold_req",   32'(bus.mem_req), 32'd1);
        check("hold_rw",    32'(RegWriteW),   32'd0);
        bus.mem_ack = 1'b1;
        tick();
        check("hold_data", ReadDataW,      32'h0BAD_F00D);
        check("hold_rwok", 32'(RegWriteW), 32'd1);
        idle_m();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, wait cycles before a bus access is abandoned (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 RegWriteM, MemWriteM  input  1 each  M-stage controls.
REQ-005 ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4.
REQ-006 funct3M  input  3  access size/sign.
REQ-007 rdM  input  5; PCplus4M, ALUResultM, WriteDataM  input  32 each.
REQ-008 mem_req, mem_we  output  1; mem_addr, mem_wdata  output  32; mem_wstrb  output  4  data bus request.
REQ-009 mem_rdata  input  32; mem_ack  input  1  bus response.
REQ-010 StallM  output  1  holds F/D/E/M stages.
REQ-011 FaultM  output  1  misaligned or reserved-size access.
REQ-012 RegWriteW  output  1; ResultSrcW  output  2; rdW  output  5; ALUResultW, ReadDataW, PCplus4W  output  32  MEM/WB register.

Function
REQ-013 Access pending = (MemWriteM or ResultSrcM==01) and not FaultM and not reset.
REQ-014 FSM states IDLE, WAIT; IDLE->WAIT when access pending and mem_ack=0; WAIT->IDLE on mem_ack=1; IDLE->IDLE on zero-wait ack.
REQ-015 mem_req = access pending (IDLE or WAIT); mem_we = MemWriteM; mem_addr = {ALUResultM[31:2],2'b00}.
REQ-016 Stores: SB replicates byte to all lanes, wstrb one-hot by addr[1:0]; SH replicates halfword, wstrb 0011/1100; SW wstrb 1111; loads wstrb 0000.
REQ-017 Loads: byte/halfword lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-018 FaultM combinational: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; load funct3 011/110/111; store funct3 >=011.
REQ-019 Faulting access: no mem_req, no stall, W receives RegWriteW=0.
REQ-020 StallM = access pending and mem_ack=0.
REQ-021 W register updates every cycle: StallM=1 -> bubble (RegWriteW=0, other W fields don't-care but deterministic hold); else M fields copied, ReadDataW = extended load data.
REQ-022 Load latency: data in ReadDataW the cycle after mem_ack; zero-wait load adds no stall.
REQ-023 mem_ack while mem_req=0 is ignored.
REQ-024 M inputs stable while StallM=1; block does not re-sample them mid-access.

Reset
REQ-025 Reset: FSM IDLE, all W outputs 0, mem_req 0, StallM 0, timeout counter 0.
REQ-026 Reset during WAIT: access abandoned; late mem_ack after reset ignored.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN defined: counter increments in WAIT; at TIMEOUT_CYCLES without ack, FSM->IDLE, FaultM pulses one cycle, StallM drops, W gets RegWriteW=0.
REQ-028 MEM_TIMEOUT_EN undefined: no counter, WAIT held indefinitely.

Structure
REQ-029 Shared package riscv_pkg: ResultSrc encodings, funct3 load/store constants, FSM state enum.
REQ-030 Sub-module lsu_align: combinational store lane/wstrb generation and load extract/extend.

Verification
REQ-031 SW addr 0x100 data 0xDEADBEEF, ack same cycle -> wstrb 1111, StallM 0, RegWriteW 0 next cycle.
REQ-032 SB addr 0x103 data 0x000000AB -> wdata 0xABABABAB, wstrb 1000.
REQ-033 LB addr 0x201 rdata 0x00008000, ack after 3 cycles -> StallM high 3 cycles, ReadDataW 0xFFFFFF80; LBU -> 0x00000080.
REQ-034 LW addr 0x202 -> FaultM 1, mem_req 0, RegWriteW 0, no stall.
REQ-035 Reset asserted in WAIT, ack next cycle -> FSM IDLE, W outputs 0, ack ignored.
REQ-036 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> StallM 4 cycles, FaultM pulse, RegWriteW 0.
